// File: rtl/sevenseg_pkg.sv
// Shared types and segment constants for the 4-digit seven-segment scan controller.
// All segment and anode encodings are active-low to match the common-anode board.
package sevenseg_pkg;

    typedef logic [6:0] seg_t;
    typedef logic [3:0] anode_t;

    localparam seg_t   SEG_BLANK = 7'h7F;
    localparam anode_t ANODE_OFF = 4'hF;

    // Segment order is {a,b,c,d,e,f,g}; index is the hex nibble value.
    localparam seg_t HEX2SEG [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    function automatic seg_t hexToSeg(input logic [3:0] nibble);
        return HEX2SEG[nibble];
    endfunction

endpackage

// File: rtl/sevenseg_scan_ctrl_tick.sv
// Refresh prescaler: free-running counter that raises tick once every DIV cycles.
module refresh_tick_gen #(
    parameter int DIV = 100000
) (
    input  logic clk_100MHz,
    input  logic rst,
    output logic tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] r_count;

    assign tick = (r_count == CNT_W'(DIV - 1));

    always_ff @(posedge clk_100MHz or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// Time-multiplexed 4-digit display scanner with a double-buffered value input.
// New values are latched into a pending buffer and only become visible at a frame boundary.
module sevenseg_scan_ctrl
    import sevenseg_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk_100MHz,
    input  logic        rst,
    input  logic        enable,
    input  logic        blank_lz,
    input  logic [15:0] value_in,
    input  logic        value_valid,
    output logic        value_ready,
    output logic [3:0]  Anode_Activate,
    output logic [6:0]  LED_out,
    output logic        frame_done
);

    logic        w_tick;
    logic        w_frameBoundary;
    logic        w_accept;
    logic        w_blank;
    logic [3:0]  w_nibble;

    logic [1:0]  r_digitIdx;
    logic [15:0] r_activeVal;
    logic [15:0] r_pendVal;
    logic        r_pending;
    anode_t      r_anode;
    seg_t        r_seg;
    logic        r_frameDone;

    refresh_tick_gen #(
        .DIV (REFRESH_DIV)
    ) u_tick (
        .clk_100MHz (clk_100MHz),
        .rst        (rst),
        .tick       (w_tick)
    );

    assign w_frameBoundary = w_tick && (r_digitIdx == 2'd3);
    assign w_accept        = value_valid && !r_pending;
    assign w_nibble        = r_activeVal[r_digitIdx*4 +: 4];

    // A digit is blank only when it and every more-significant nibble are zero.
    always_comb begin
        w_blank = 1'b0;
        if (blank_lz) begin
            case (r_digitIdx)
                2'd3:    w_blank = (r_activeVal[15:12] == 4'h0);
                2'd2:    w_blank = (r_activeVal[15:8] == 8'h00);
                2'd1:    w_blank = (r_activeVal[15:4] == 12'h000);
                default: w_blank = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk_100MHz or posedge rst) begin
        if (rst) begin
            r_digitIdx  <= 2'd0;
            r_activeVal <= 16'h0000;
            r_pendVal   <= 16'h0000;
            r_pending   <= 1'b0;
            r_anode     <= ANODE_OFF;
            r_seg       <= SEG_BLANK;
            r_frameDone <= 1'b0;
        end else begin
            r_frameDone <= w_frameBoundary;

            if (w_tick) begin
                r_digitIdx <= r_digitIdx + 2'd1;
            end

            // Accept and transfer are mutually exclusive because accept needs an empty buffer.
            if (w_frameBoundary && r_pending) begin
                r_activeVal <= r_pendVal;
                r_pending   <= 1'b0;
            end

            if (w_accept) begin
                r_pendVal <= value_in;
                r_pending <= 1'b1;
            end

            if (!enable || w_blank) begin
                r_anode <= ANODE_OFF;
                r_seg   <= SEG_BLANK;
            end else begin
                r_anode <= ~(4'b0001 << r_digitIdx);
                r_seg   <= hexToSeg(w_nibble);
            end
        end
    end

    assign value_ready    = ~r_pending;
    assign Anode_Activate = r_anode;
    assign LED_out        = r_seg;
    assign frame_done     = r_frameDone;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Directed self-checking bench for sevenseg_scan_ctrl with a short refresh divider.
// Each frame is 16 cycles: four slots of four cycles, digit 0 first after a boundary.
module tb_sevenseg_scan_ctrl;

    logic        clk_100MHz = 1'b0;
    logic        rst;
    logic        enable;
    logic        blank_lz;
    logic [15:0] value_in;
    logic        value_valid;
    logic        value_ready;
    logic [3:0]  Anode_Activate;
    logic [6:0]  LED_out;
    logic        frame_done;

    int total = 0;
    int bad   = 0;

    localparam logic [15:0] AN_ALL   = 16'h7BDE;
    localparam logic [27:0] SEG_1234 = {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100};
    localparam logic [27:0] SEG_ABCD = {7'b0001000, 7'b1100000, 7'b0110001, 7'b1000010};
    localparam logic [27:0] SEG_00F0 = {7'b0000001, 7'b0000001, 7'b0111000, 7'b0000001};
    localparam logic [27:0] SEG_0000 = {7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001};

    always #5 clk_100MHz = ~clk_100MHz;

    sevenseg_scan_ctrl #(
        .REFRESH_DIV (4)
    ) dut (
        .clk_100MHz     (clk_100MHz),
        .rst            (rst),
        .enable         (enable),
        .blank_lz       (blank_lz),
        .value_in       (value_in),
        .value_valid    (value_valid),
        .value_ready    (value_ready),
        .Anode_Activate (Anode_Activate),
        .LED_out        (LED_out),
        .frame_done     (frame_done)
    );

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] val, input logic valid);
        value_in    = val;
        value_valid = valid;
    endtask

    task automatic waitFrame(input string tag);
        int n = 0;
        do begin
            @(negedge clk_100MHz);
            n++;
        end while (frame_done !== 1'b1 && n < 40);
        checkOutput({tag, "_frame_seen"}, 16'(frame_done), 16'h0001);
    endtask

    // Starts just after a boundary edge and ends on the next boundary.
    task automatic scanCheck(input string tag, input logic [15:0] expAn, input logic [27:0] expSeg,
                             input logic expReady, input int firstCycle, input int loadCycle,
                             input logic [15:0] loadVal);
        logic rdy;
        for (int c = firstCycle; c < 16; c++) begin
            @(negedge clk_100MHz);
            checkOutput($sformatf("%s_an_c%0d", tag, c), 16'(Anode_Activate), 16'(expAn[(c/4)*4 +: 4]));
            checkOutput($sformatf("%s_seg_c%0d", tag, c), 16'(LED_out), 16'(expSeg[(c/4)*7 +: 7]));
            if (c < 15) begin
                rdy = (loadCycle >= 0 && c > loadCycle) ? 1'b0 : expReady;
                checkOutput($sformatf("%s_rdy_c%0d", tag, c), 16'(value_ready), 16'(rdy));
                checkOutput($sformatf("%s_fd_c%0d", tag, c), 16'(frame_done), 16'h0000);
            end
            if (c == loadCycle) applyStimulus(loadVal, 1'b1);
        end
        value_valid = 1'b0;
        checkOutput({tag, "_fd_period"}, 16'(frame_done), 16'h0001);
    endtask

    initial begin
        rst         = 1'b1;
        enable      = 1'($urandom);
        blank_lz    = 1'($urandom);
        value_valid = 1'($urandom);
        value_in    = 16'($urandom);
        #12;
        checkOutput("rst_an", 16'(Anode_Activate), 16'h000F);
        checkOutput("rst_seg", 16'(LED_out), 16'h007F);
        checkOutput("rst_rdy", 16'(value_ready), 16'h0001);
        checkOutput("rst_fd", 16'(frame_done), 16'h0000);

        @(negedge clk_100MHz);
        rst      = 1'b0;
        enable   = 1'b1;
        blank_lz = 1'b0;
        applyStimulus(16'h0000, 1'b0);

        @(negedge clk_100MHz);
        applyStimulus(16'h1234, 1'b1);
        @(negedge clk_100MHz);
        value_valid = 1'b0;
        checkOutput("load1_rdy", 16'(value_ready), 16'h0000);

        waitFrame("f1");
        scanCheck("s1234a", AN_ALL, SEG_1234, 1'b1, 0, -1, 16'h0000);
        scanCheck("s1234b", AN_ALL, SEG_1234, 1'b1, 0, -1, 16'h0000);

        applyStimulus(16'hABCD, 1'b1);
        @(negedge clk_100MHz);
        checkOutput("tear_rdy", 16'(value_ready), 16'h0000);
        checkOutput("tear_an", 16'(Anode_Activate), 16'h000E);
        checkOutput("tear_seg", 16'(LED_out), 16'h004C);
        applyStimulus(16'h5555, 1'b1);
        scanCheck("tear", AN_ALL, SEG_1234, 1'b0, 1, -1, 16'h0000);
        scanCheck("abcd1", AN_ALL, SEG_ABCD, 1'b1, 0, 14, 16'h00F0);
        scanCheck("abcd2", AN_ALL, SEG_ABCD, 1'b0, 0, -1, 16'h0000);
        scanCheck("f0", AN_ALL, SEG_00F0, 1'b1, 0, 13, 16'h0042);

        blank_lz = 1'b1;
        scanCheck("lz42", 16'hFFDE, {7'h7F, 7'h7F, 7'b1001100, 7'b0010010}, 1'b1, 0, 3, 16'h0000);
        scanCheck("lz00", 16'hFFFE, {7'h7F, 7'h7F, 7'h7F, 7'b0000001}, 1'b1, 0, 2, 16'h1234);
        blank_lz = 1'b0;

        repeat (8) @(negedge clk_100MHz);
        enable = 1'b0;
        @(negedge clk_100MHz);
        checkOutput("en_off_an", 16'(Anode_Activate), 16'h000F);
        checkOutput("en_off_seg", 16'(LED_out), 16'h007F);
        repeat (3) @(negedge clk_100MHz);
        checkOutput("en_off_late_an", 16'(Anode_Activate), 16'h000F);
        enable = 1'b1;
        @(negedge clk_100MHz);
        checkOutput("en_on_an", 16'(Anode_Activate), 16'h0007);
        checkOutput("en_on_seg", 16'(LED_out), 16'h004F);
        repeat (3) @(negedge clk_100MHz);
        checkOutput("en_fd", 16'(frame_done), 16'h0001);

        applyStimulus(16'h5A5A, 1'b1);
        @(negedge clk_100MHz);
        value_valid = 1'b0;
        checkOutput("pre_rst_rdy", 16'(value_ready), 16'h0000);
        #2 rst = 1'b1;
        #1;
        checkOutput("arst_rdy", 16'(value_ready), 16'h0001);
        checkOutput("arst_an", 16'(Anode_Activate), 16'h000F);
        checkOutput("arst_seg", 16'(LED_out), 16'h007F);
        checkOutput("arst_fd", 16'(frame_done), 16'h0000);
        @(negedge clk_100MHz);
        rst = 1'b0;
        waitFrame("post_rst");
        scanCheck("rst0", AN_ALL, SEG_0000, 1'b1, 0, -1, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
